aes_sbox_engine: RTL and testbench
==================================

// Module: aes_sbox_engine
// PURPOSE
//  Iterative SubBytes / InvSubBytes engine for a full 128-bit AES state.
//  LANES S-box instances are time-shared over the 16 state bytes. A block takes 16/LANES beats.
//  Forward or inverse substitution is selected per block. Valid/ready handshakes on both sides.
//  Sits between the round controller and ShiftRows; trades area against latency via LANES.
// PARAMETERS
//  LANES   4  S-box lanes per beat; legal 1,2,4,8,16; any other value -> elaboration error
//  INV_EN  1  1: instantiate inverse S-box and honour in_inv; 0: forward only, in_inv ignored
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    input block valid
//  in_ready   out  1    engine can accept a block this cycle
//  in_state   in   128  input state; byte i = in_state[127-8*i -: 8] (byte 0 at MSB)
//  in_inv     in   1    1 = InvSubBytes, 0 = SubBytes; sampled with in_state
//  out_valid  out  1    out_state holds a finished block
//  out_ready  in   1    consumer accepts out_state this cycle
//  out_state  out  128  substituted state, same byte order as in_state
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  - Parameter: BEATS = 16/LANES.
//  - FSM states: IDLE, RUN, DONE.
//  - Reset (rst=1 at a clock edge):
//      state->IDLE; beat counter=0; out_state=0; out_valid=0; busy=0.
//      Any in-flight block is discarded silently.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from out_ready.
//  - Accept: on in_valid & in_ready, register in_state into the work register, latch the mode, clear cnt, go to RUN.
//      Mode = in_inv & INV_EN.
//      in_state and in_inv are not sampled at any other time; changes after accept have no effect.
//  - RUN, beat cnt (0..BEATS-1): lane j substitutes byte k = cnt*LANES+j in place.
//      Lane j uses Sbox[] (mode 0) or InvSbox[] (mode 1).
//      cnt wraps after BEATS-1; that beat moves the FSM to DONE.
//      No beat is skipped or repeated.
//  - DONE: out_valid=1 and out_state = work register.
//      out_valid and out_state hold stable until out_ready=1.
//  - Leaving DONE, when out_ready=1:
//      in_valid=0 -> IDLE; out_valid drops the next cycle.
//      in_valid=1 -> the new block is accepted in the same cycle (simultaneous release+accept) and the FSM goes straight to RUN.
//  - Latency: accept at edge E0; out_valid is seen high after edge E0+BEATS. Example: LANES=4 gives 4 cycles.
//    Throughput: 1 block per BEATS+1 cycles, achieved with back-to-back handshakes.
//  - out_state is updated only on accept and during RUN.
//    After the output handshake it keeps the last result, but out_valid=0.
//  - in_valid while in RUN: in_ready=0, the block is not taken, and the producer must hold it.
//  - LANES=16: BEATS=1, so RUN lasts exactly one cycle.
//  - S-box tables are the FIPS-197 forward and inverse tables. Each lane is purely combinational; the only registers are the work register, cnt, mode and the FSM.
// TESTING
//  1. LANES=4, fwd, in_state=00112233445566778899aabbccddeeff -> out_state=638293c31bfc33f5c4eeacea4bc12816, out_valid exactly 4 cycles after accept.
//  2. inv, in_state=638293c31bfc33f5c4eeacea4bc12816 -> out_state=00112233445566778899aabbccddeeff. With INV_EN=0 the same stimulus gives the forward result instead.
//  3. out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable and in_ready=0. Then out_ready=1 together with a new in_valid -> block accepted that cycle, FSM in RUN.
//  4. Assert rst during beat 2 of RUN -> next cycle: IDLE, out_valid=0, out_state=0, in_ready=1. The aborted block never appears at the output.
//  5. Sweep LANES in {1,2,4,8,16} with in_state all 00 (fwd) -> all bytes 63, latency = 16,8,4,2,1. All 00 (inv) -> all bytes 52.
//  6. Random in_valid/out_ready stalls over 1000 blocks, checked against a reference model -> zero mismatches, no dropped or duplicated blocks.

Source files
------------

// File: rtl/aes_sbox_engine.sv
// Iterative SubBytes/InvSubBytes engine: LANES S-boxes time-shared over a 128-bit state.
// Ports: clk/rst, in_valid/in_ready/in_state/in_inv, out_valid/out_ready/out_state, busy.
module aes_sbox_engine #(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int BEATS = 16 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sbox_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 = a^-1 (and 0 -> 0): build a^127 by square-and-multiply, then square
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] y;
    y = ginv(a);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]}
             ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]}
      ^ {s[1:0], s[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_mode;
  logic [127:0]    r_work;
  logic [127:0]    w_work_nxt;
  logic            w_accept;
  logic            w_last;
  logic [3:0]      w_idx    [LANES];
  logic [7:0]      w_lane_in  [LANES];
  logic [7:0]      w_lane_out [LANES];

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == CW'(BEATS - 1));

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      w_idx[j]     = 4'(int'(r_cnt) * LANES + j);
      w_lane_in[j] = r_work[127 - 8 * int'(w_idx[j]) -: 8];
    end
  end

  // r_mode is held at 0 when INV_EN=0, so the inverse path folds away
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0] w_fwd;
    assign w_fwd = sbox_fwd(w_lane_in[j]);
    assign w_lane_out[j] = r_mode ? sbox_inv(w_lane_in[j]) : w_fwd;
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int j = 0; j < LANES; j++) begin
      w_work_nxt[127 - 8 * int'(w_idx[j]) -: 8] = w_lane_out[j];
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_next = in_valid ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign out_state = r_work;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_work  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_work <= in_state;
        r_cnt  <= '0;
        r_mode <= in_inv & INV_EN;
      end else if (r_state == S_RUN) begin
        r_work <= w_work_nxt;
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_sbox_engine.sv
// Bench for aes_sbox_engine: directed known-answer, hold, reset, lane sweep
// and random-stall scoreboard runs against a log/antilog S-box model.
module tb_aes_sbox_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         m_iv, m_ir, m_inv, m_ov, m_or, m_busy;
  logic [127:0] m_st, m_os;
  logic         n_ir, n_ov, n_busy;
  logic [127:0] n_os;
  logic         s_iv, s_inv, s_or;
  logic [127:0] s_st;
  logic [4:0]   sw_ir, sw_ov, sw_busy;
  logic [127:0] sw_os [5];

  aes_sbox_engine #(.LANES(4), .INV_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(m_iv), .in_ready(m_ir),
    .in_state(m_st), .in_inv(m_inv),
    .out_valid(m_ov), .out_ready(m_or),
    .out_state(m_os), .busy(m_busy)
  );

  aes_sbox_engine #(.LANES(4), .INV_EN(1'b0)) u_noinv (
    .clk(clk), .rst(rst),
    .in_valid(m_iv), .in_ready(n_ir),
    .in_state(m_st), .in_inv(m_inv),
    .out_valid(n_ov), .out_ready(m_or),
    .out_state(n_os), .busy(n_busy)
  );

  for (genvar g = 0; g < 5; g++) begin : g_sw
    aes_sbox_engine #(.LANES(1 << g), .INV_EN(1'b1)) u_sw (
      .clk(clk), .rst(rst),
      .in_valid(s_iv), .in_ready(sw_ir[g]),
      .in_state(s_st), .in_inv(s_inv),
      .out_valid(sw_ov[g]), .out_ready(s_or),
      .out_state(sw_os[g]), .busy(sw_busy[g])
    );
  end

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   fw  [256];
  logic [7:0]   ivt [256];
  logic [127:0] sb [$];
  logic         prev_hold = 1'b0;
  logic [127:0] prev_os;
  logic         g_acc;
  int           n_rel = 0;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // tables from generator 3: exp/log, inverse, then bitwise affine
  task automatic build_tables();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] p, y, b, c;
    p = 8'h01;
    c = 8'h63;
    lg[0] = 0;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ ({p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00));
    end
    for (int x = 0; x < 256; x++) begin
      y = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int i = 0; i < 8; i++)
        b[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8]
             ^ y[(i + 6) % 8] ^ y[(i + 7) % 8] ^ c[i];
      fw[x]  = b;
      ivt[b] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st,
                                         input logic inv);
    logic [127:0] r;
    logic [7:0]   v;
    for (int i = 0; i < 16; i++) begin
      v = st[127 - 8 * i -: 8];
      r[127 - 8 * i -: 8] = inv ? ivt[v] : fw[v];
    end
    return r;
  endfunction

  task automatic cyc();
    logic [127:0] e;
    @(negedge clk);
    g_acc = 1'b0;
    if (!rst) begin
      if (prev_hold) begin
        chk("hold_valid", 128'(m_ov), 128'd1);
        chk("hold_state", m_os, prev_os);
      end
      if (m_iv && m_ir) begin
        sb.push_back(model(m_st, m_inv));
        g_acc = 1'b1;
      end
      if (m_ov && m_or) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL sb_extra observed=%h expected=none", m_os);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_data", m_os, e);
          n_rel++;
        end
      end
    end
    prev_hold = !rst && m_ov && !m_or;
    prev_os   = m_os;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!m_ov && lat < 40) begin
      cyc();
      lat++;
    end
  endtask

  initial begin
    int lat, sent, base, cycles;
    int first [5];
    build_tables();
    rst = 1'b1;
    m_iv = 1'b0; m_inv = 1'b0; m_or = 1'b0; m_st = '0;
    s_iv = 1'b0; s_inv = 1'b0; s_or = 1'b0; s_st = '0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_ovalid", 128'(m_ov), 128'd0);
    chk("rst_ostate", m_os, 128'd0);
    chk("rst_iready", 128'(m_ir), 128'd1);
    chk("rst_busy", 128'(m_busy), 128'd0);
    chk("rst_noinv", {126'd0, n_ir, n_busy}, 128'd2);

    // forward known answer, held in DONE
    m_st = PT; m_inv = 1'b0; m_iv = 1'b1;
    cyc();
    m_iv = 1'b0;
    wait_done(lat);
    chk("fwd_lat", 128'(lat), 128'd4);
    chk("fwd_state", m_os, CT);
    chk("fwd_noinv", n_os, CT);

    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_iready", 128'(m_ir), 128'd0);
    end

    // release and accept inverse block in the same cycle
    m_st = CT; m_inv = 1'b1; m_iv = 1'b1; m_or = 1'b1;
    #1;
    chk("rel_iready", 128'(m_ir), 128'd1);
    cyc();
    m_iv = 1'b0; m_or = 1'b0;
    chk("rel_busy", 128'(m_busy), 128'd1);
    chk("rel_ovalid", 128'(m_ov), 128'd0);
    chk("rel_run_ir", 128'(m_ir), 128'd0);
    wait_done(lat);
    chk("inv_lat", 128'(lat), 128'd4);
    chk("inv_state", m_os, PT);
    chk("inv_noinv", n_os, model(CT, 1'b0));
    m_or = 1'b1;
    cyc();
    chk("drain_ovalid", 128'(m_ov), 128'd0);
    chk("drain_keep", m_os, PT);

    // reset during beat 2
    m_st = {$urandom, $urandom, $urandom, $urandom};
    m_inv = 1'b0; m_iv = 1'b1;
    cyc();
    m_iv = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    chk("abort_ovalid", 128'(m_ov), 128'd0);
    chk("abort_ostate", m_os, 128'd0);
    chk("abort_iready", 128'(m_ir), 128'd1);
    chk("abort_busy", 128'(m_busy), 128'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("abort_quiet", 128'(m_ov), 128'd0);
    end

    // lane sweep, forward then inverse of all-zero state
    for (int pass = 0; pass < 2; pass++) begin
      chk("sw_iready", 128'(sw_ir), 128'h1f);
      s_st = '0; s_inv = pass[0]; s_iv = 1'b1;
      cyc();
      s_iv = 1'b0;
      chk("sw_busy", 128'(sw_busy), 128'h1f);
      for (int g = 0; g < 5; g++) first[g] = 0;
      for (int c = 1; c <= 20; c++) begin
        cyc();
        for (int g = 0; g < 5; g++)
          if (sw_ov[g] && first[g] == 0) first[g] = c;
      end
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("sw_lat%0d", g), 128'(first[g]), 128'(16 >> g));
        chk($sformatf("sw_state%0d", g), sw_os[g],
            pass == 0 ? {16{8'h63}} : {16{8'h52}});
      end
      s_or = 1'b1;
      cyc();
      s_or = 1'b0;
    end

    // random stalls, 1000 blocks
    m_iv = 1'b0; sent = 0; base = n_rel; cycles = 0;
    while (n_rel - base < 1000 && cycles < 60000) begin
      m_or = ($urandom_range(0, 3) != 0);
      cyc();
      if (g_acc || !m_iv) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          m_iv  = 1'b1;
          m_st  = {$urandom, $urandom, $urandom, $urandom};
          m_inv = 1'($urandom_range(0, 1));
          sent++;
        end else begin
          m_iv = 1'b0;
        end
      end
      cycles++;
    end
    chk("rand_count", 128'(n_rel - base), 128'd1000);
    chk("rand_sb_empty", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
